// File: rtl/sdram_frame_arbiter_if.sv
// ----------------------------------------------------------------------------
// sdram_frame_arbiter_if
//   Burst command bus between the frame arbiter and the SDRAM controller.
//   master : arbiter side, drives the command, receives ready/done.
//   slave  : controller side, accepts the command, reports ready/done.
// Signals
//   mem_cmd_valid_o  burst command valid
//   mem_cmd_wr_o     1 = write burst, 0 = read burst
//   mem_cmd_addr_o   burst start word address (ADDR_W bits)
//   mem_cmd_len_o    burst length in words
//   mem_cmd_ready_i  controller accepts the command (valid & ready)
//   mem_done_i       1-cycle pulse, last word of the burst transferred
// ----------------------------------------------------------------------------
interface sdram_frame_arbiter_if #(
   parameter int ADDR_W = 24
);
   logic              mem_cmd_valid_o;
   logic              mem_cmd_wr_o;
   logic [ADDR_W-1:0] mem_cmd_addr_o;
   logic [8:0]        mem_cmd_len_o;
   logic              mem_cmd_ready_i;
   logic              mem_done_i;

   modport master (
      output mem_cmd_valid_o,
      output mem_cmd_wr_o,
      output mem_cmd_addr_o,
      output mem_cmd_len_o,
      input  mem_cmd_ready_i,
      input  mem_done_i
   );

   modport slave (
      input  mem_cmd_valid_o,
      input  mem_cmd_wr_o,
      input  mem_cmd_addr_o,
      input  mem_cmd_len_o,
      output mem_cmd_ready_i,
      output mem_done_i
   );
endinterface

// File: rtl/sdram_frame_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_frame_arbiter
//   Shares the single SDRAM burst command port between the display reader
//   and the frame writer. Owns two ping-pong frame buffer units, generates
//   burst start addresses and swaps display/write units at frame_sync only
//   once the write unit holds a complete frame.
// Ports
//   clk, rst         system clock, asynchronous active-high reset
//   frame_sync_i     1-cycle pulse at start of a VGA frame
//   rd_req_i         display FIFO wants one burst (level)
//   wr_req_i         writer FIFO has one burst ready (level)
//   rd_gnt_o         high during read command + data phase
//   wr_gnt_o         high during write command + data phase
//   wr_full_o        write unit holds a complete frame, awaiting swap
//   swap_o           1-cycle pulse when the units swap
//   rd_buf_o         unit index being displayed
//   wr_buf_o         unit index being written
//   mem              burst command bus to the SDRAM controller (master)
// ----------------------------------------------------------------------------
module sdram_frame_arbiter #(
   parameter int FRAME_WORDS = 1024*768,
   parameter int UNIT_WORDS  = 1024*1024,
   parameter int BURST_LEN   = 256,
   parameter int ADDR_W      = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_sync_i,
   input  logic                  rd_req_i,
   input  logic                  wr_req_i,
   output logic                  rd_gnt_o,
   output logic                  wr_gnt_o,
   output logic                  wr_full_o,
   output logic                  swap_o,
   output logic                  rd_buf_o,
   output logic                  wr_buf_o,
   sdram_frame_arbiter_if.master mem
);

   // Offsets must be able to hold FRAME_WORDS itself (write offset parks there).
   localparam int OFS_W = $clog2(FRAME_WORDS + 1);

   localparam logic [OFS_W-1:0]  BURST_OFS = OFS_W'(BURST_LEN);
   localparam logic [OFS_W-1:0]  FRAME_OFS = OFS_W'(FRAME_WORDS);
   localparam logic [OFS_W-1:0]  RD_LAST   = OFS_W'(FRAME_WORDS - BURST_LEN);
   localparam logic [ADDR_W-1:0] UNIT_BASE = ADDR_W'(UNIT_WORDS);

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      RD_BUSY,
      WR_CMD,
      WR_BUSY
   } state_t;

   state_t           state_reg, state_next;
   logic [OFS_W-1:0] rd_ofs_reg, rd_ofs_next;
   logic [OFS_W-1:0] wr_ofs_reg, wr_ofs_next;
   logic             wr_full_reg, wr_full_next;
   logic             rd_buf_reg, rd_buf_next;
   logic             wr_buf_reg, wr_buf_next;
   logic             sync_pend_reg, sync_pend_next;
   logic             swap_reg, swap_next;

   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         rd_ofs_reg    <= '0;
         wr_ofs_reg    <= '0;
         wr_full_reg   <= 1'b0;
         rd_buf_reg    <= 1'b1;
         wr_buf_reg    <= 1'b0;
         sync_pend_reg <= 1'b0;
         swap_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         rd_ofs_reg    <= rd_ofs_next;
         wr_ofs_reg    <= wr_ofs_next;
         wr_full_reg   <= wr_full_next;
         rd_buf_reg    <= rd_buf_next;
         wr_buf_reg    <= wr_buf_next;
         sync_pend_reg <= sync_pend_next;
         swap_reg      <= swap_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      rd_ofs_next    = rd_ofs_reg;
      wr_ofs_next    = wr_ofs_reg;
      wr_full_next   = wr_full_reg;
      rd_buf_next    = rd_buf_reg;
      wr_buf_next    = wr_buf_reg;
      swap_next      = 1'b0;
      // A sync pulse is remembered until the arbiter is idle, so it never
      // disturbs a burst in flight.
      sync_pend_next = sync_pend_reg | frame_sync_i;

      case (state_reg)
         IDLE: begin
            if (sync_pend_reg) begin
               // A pulse arriving in the apply cycle belongs to the next frame.
               sync_pend_next = frame_sync_i;
               rd_ofs_next    = '0;
               if (wr_full_reg) begin
                  rd_buf_next  = wr_buf_reg;
                  wr_buf_next  = ~wr_buf_reg;
                  wr_ofs_next  = '0;
                  wr_full_next = 1'b0;
                  swap_next    = 1'b1;
               end
            end else if (rd_req_i) begin
               state_next = RD_CMD;
            end else if (wr_req_i && !wr_full_reg) begin
               state_next = WR_CMD;
            end
         end
         RD_CMD: begin
            if (mem.mem_cmd_ready_i) state_next = RD_BUSY;
         end
         RD_BUSY: begin
            if (mem.mem_done_i) begin
               state_next  = IDLE;
               // Wrap so the display re-reads the same unit if sync is late.
               rd_ofs_next = (rd_ofs_reg == RD_LAST) ? '0 : rd_ofs_reg + BURST_OFS;
            end
         end
         WR_CMD: begin
            if (mem.mem_cmd_ready_i) state_next = WR_BUSY;
         end
         WR_BUSY: begin
            if (mem.mem_done_i) begin
               state_next   = IDLE;
               wr_ofs_next  = wr_ofs_reg + BURST_OFS;
               wr_full_next = ((wr_ofs_reg + BURST_OFS) == FRAME_OFS);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Offsets only change in IDLE or at burst completion, so the address is
   // stable for the whole command phase.
   assign rd_addr = (rd_buf_reg ? UNIT_BASE : '0) + ADDR_W'(rd_ofs_reg);
   assign wr_addr = (wr_buf_reg ? UNIT_BASE : '0) + ADDR_W'(wr_ofs_reg);

   assign rd_gnt_o  = (state_reg == RD_CMD) || (state_reg == RD_BUSY);
   assign wr_gnt_o  = (state_reg == WR_CMD) || (state_reg == WR_BUSY);
   assign wr_full_o = wr_full_reg;
   assign swap_o    = swap_reg;
   assign rd_buf_o  = rd_buf_reg;
   assign wr_buf_o  = wr_buf_reg;

   // Decoded straight from the state register so reset drops valid at once.
   assign mem.mem_cmd_valid_o = (state_reg == RD_CMD) || (state_reg == WR_CMD);
   assign mem.mem_cmd_wr_o    = wr_gnt_o;
   assign mem.mem_cmd_addr_o  = wr_gnt_o ? wr_addr : rd_addr;
   assign mem.mem_cmd_len_o   = 9'(BURST_LEN);

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
module tb_sdram_frame_arbiter;
   localparam int FW = 1024;
   localparam int UW = 4096;
   localparam int BL = 256;
   localparam int AW = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic frame_sync = 1'b0;
   logic rd_req = 1'b0;
   logic wr_req = 1'b0;
   logic rd_gnt, wr_gnt, wr_full, swap, rd_buf, wr_buf;

   sdram_frame_arbiter_if #(.ADDR_W(AW)) mem_if ();

   sdram_frame_arbiter #(
      .FRAME_WORDS(FW), .UNIT_WORDS(UW), .BURST_LEN(BL), .ADDR_W(AW)
   ) dut (
      .clk(clk), .rst(rst), .frame_sync_i(frame_sync),
      .rd_req_i(rd_req), .wr_req_i(wr_req),
      .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt), .wr_full_o(wr_full),
      .swap_o(swap), .rd_buf_o(rd_buf), .wr_buf_o(wr_buf),
      .mem(mem_if.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- SDRAM controller model ----------------
   int ready_lat = 1;
   int done_dly  = 256;
   bit ctl_busy  = 0;
   bit ctl_seen  = 0;
   int ctl_wait  = 0;
   int ctl_cnt   = 0;
   bit              q_wr[$];
   logic [AW-1:0]   q_addr[$];
   logic [8:0]      q_len[$];
   int swap_cnt = 0;

   initial begin : ctl
      mem_if.mem_cmd_ready_i = 1'b0;
      mem_if.mem_done_i      = 1'b0;
      forever begin
         @(negedge clk);
         mem_if.mem_cmd_ready_i = 1'b0;
         mem_if.mem_done_i      = 1'b0;
         if (rst) begin
            ctl_busy = 0;
            ctl_seen = 0;
         end else if (ctl_busy) begin
            if (ctl_cnt <= 1) begin
               mem_if.mem_done_i = 1'b1;
               ctl_busy = 0;
            end else begin
               ctl_cnt--;
            end
         end else if (mem_if.mem_cmd_valid_o) begin
            if (!ctl_seen) begin
               ctl_seen = 1;
               ctl_wait = ready_lat;
            end
            if (ctl_wait == 0) begin
               mem_if.mem_cmd_ready_i = 1'b1;
               ctl_busy = 1;
               ctl_seen = 0;
               ctl_cnt  = done_dly;
               q_wr.push_back(mem_if.mem_cmd_wr_o);
               q_addr.push_back(mem_if.mem_cmd_addr_o);
               q_len.push_back(mem_if.mem_cmd_len_o);
            end else begin
               ctl_wait--;
            end
         end
      end
   end

   // Continuous invariants, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ((rd_gnt && wr_gnt) || (rd_buf === wr_buf) ||
             (mem_if.mem_cmd_valid_o && (mem_if.mem_cmd_wr_o !== wr_gnt || !(rd_gnt || wr_gnt)))) begin
            errors++;
            $display("FAIL invariant: rd_gnt=%b wr_gnt=%b rd_buf=%b wr_buf=%b valid=%b wr=%b required exclusive grants, distinct units, cmd matching grant",
                     rd_gnt, wr_gnt, rd_buf, wr_buf, mem_if.mem_cmd_valid_o, mem_if.mem_cmd_wr_o);
         end
         if (swap) swap_cnt++;
      end
   end

   // ---------------- behavioural reference model ----------------
   int m_rd_buf, m_wr_buf, m_rd_ofs, m_wr_ofs;
   bit m_full;

   function automatic void model_reset();
      m_rd_buf = 1; m_wr_buf = 0; m_rd_ofs = 0; m_wr_ofs = 0; m_full = 0;
   endfunction

   function automatic logic [AW-1:0] exp_rd();
      logic [AW-1:0] a;
      a = AW'(m_rd_buf * UW + m_rd_ofs);
      m_rd_ofs = (m_rd_ofs + BL) % FW;
      return a;
   endfunction

   function automatic logic [AW-1:0] exp_wr();
      logic [AW-1:0] a;
      a = AW'(m_wr_buf * UW + m_wr_ofs);
      m_wr_ofs = m_wr_ofs + BL;
      if (m_wr_ofs == FW) m_full = 1;
      return a;
   endfunction

   function automatic bit model_sync();
      int t;
      m_rd_ofs = 0;
      if (m_full) begin
         t = m_rd_buf; m_rd_buf = m_wr_buf; m_wr_buf = t;
         m_wr_ofs = 0; m_full = 0;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic do_reset();
      rst = 1'b1; rd_req = 0; wr_req = 0; frame_sync = 0;
      repeat (3) @(negedge clk);
      q_wr.delete(); q_addr.delete(); q_len.delete();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic get_cmd(input int budget, output bit got, output bit wr,
                          output logic [AW-1:0] addr, output logic [8:0] len);
      got = 0; wr = 0; addr = '0; len = '0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk); #1;
         if (q_addr.size() > 0) begin
            got  = 1;
            wr   = q_wr.pop_front();
            addr = q_addr.pop_front();
            len  = q_len.pop_front();
         end
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk); #1;
         if (!rd_gnt && !wr_gnt) ok = 1;
      end
   endtask

   task automatic pulse_sync();
      @(negedge clk); frame_sync = 1'b1;
      @(negedge clk); frame_sync = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      @(negedge clk); #1;
      checks++;
      if (rd_buf !== 1'b1 || wr_buf !== 1'b0) begin
         errors++; $display("FAIL reset_bufs: rd_buf=%b wr_buf=%b required 1/0", rd_buf, wr_buf);
      end
      checks++;
      if (wr_full !== 1'b0 || swap !== 1'b0) begin
         errors++; $display("FAIL reset_flags: wr_full=%b swap=%b required 0/0", wr_full, swap);
      end
      checks++;
      if (mem_if.mem_cmd_valid_o !== 1'b0 || rd_gnt !== 1'b0 || wr_gnt !== 1'b0) begin
         errors++; $display("FAIL reset_grants: valid=%b rd_gnt=%b wr_gnt=%b required 0", mem_if.mem_cmd_valid_o, rd_gnt, wr_gnt);
      end
      $display("reset: rd_buf=%b wr_buf=%b", rd_buf, wr_buf);
   endtask

   task automatic test_fill_frame();
      bit got, wr, ok;
      logic [AW-1:0] addr, e;
      logic [8:0] len;
      int g;
      ready_lat = 1; done_dly = 256;
      wr_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         get_cmd(600, got, wr, addr, len);
         e = exp_wr();
         checks++;
         if (!got || wr !== 1'b1 || addr !== e || len !== 9'd256) begin
            errors++; $display("FAIL fill_write%0d: got=%b wr=%b addr=%h len=%0d required wr=1 addr=%h len=256", k, got, wr, addr, len, e);
         end
         $display("fill: write burst addr=%h", addr);
      end
      wait_idle(600, ok);
      checks++;
      if (!ok || wr_full !== 1'b1) begin
         errors++; $display("FAIL fill_full: idle=%b wr_full=%b required 1/1", ok, wr_full);
      end
      g = 0;
      repeat (40) begin @(negedge clk); #1; if (wr_gnt || mem_if.mem_cmd_valid_o) g++; end
      checks++;
      if (g != 0) begin
         errors++; $display("FAIL fill_no_fifth: grant cycles=%0d required 0", g);
      end
      wr_req = 1'b0;
   endtask

   task automatic test_swap();
      bit got, wr, ok, sw;
      logic [AW-1:0] addr, e;
      logic [8:0] len;
      int s0;
      s0 = swap_cnt;
      pulse_sync();
      repeat (4) @(negedge clk);
      #1;
      sw = model_sync();
      checks++;
      if (swap_cnt - s0 != int'(sw)) begin
         errors++; $display("FAIL swap_pulse: pulses=%0d required %0d", swap_cnt - s0, sw);
      end
      checks++;
      if (rd_buf !== 1'(m_rd_buf) || wr_buf !== 1'(m_wr_buf) || wr_full !== m_full) begin
         errors++; $display("FAIL swap_state: rd_buf=%b wr_buf=%b wr_full=%b required %0d %0d %b", rd_buf, wr_buf, wr_full, m_rd_buf, m_wr_buf, m_full);
      end
      wr_req = 1'b1;
      get_cmd(600, got, wr, addr, len);
      wr_req = 1'b0;
      e = exp_wr();
      checks++;
      if (!got || wr !== 1'b1 || addr !== e) begin
         errors++; $display("FAIL swap_next_write: got=%b wr=%b addr=%h required wr=1 addr=%h", got, wr, addr, e);
      end
      $display("swap: write burst addr=%h", addr);
      wait_idle(600, ok);
   endtask

   task automatic test_priority();
      bit got, wr, ok;
      logic [AW-1:0] addr, e;
      logic [8:0] len;
      @(negedge clk);
      rd_req = 1'b1; wr_req = 1'b1;
      get_cmd(600, got, wr, addr, len);
      rd_req = 1'b0;
      e = exp_rd();
      checks++;
      if (!got || wr !== 1'b0 || addr !== e) begin
         errors++; $display("FAIL priority_read: got=%b wr=%b addr=%h required wr=0 addr=%h", got, wr, addr, e);
      end
      $display("priority: read burst addr=%h", addr);
      get_cmd(600, got, wr, addr, len);
      wr_req = 1'b0;
      e = exp_wr();
      checks++;
      if (!got || wr !== 1'b1 || addr !== e) begin
         errors++; $display("FAIL priority_write: got=%b wr=%b addr=%h required wr=1 addr=%h", got, wr, addr, e);
      end
      $display("priority: write burst addr=%h", addr);
      wait_idle(600, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL priority_idle: idle=0 required 1"); end
   endtask

   task automatic test_sync_mid_burst();
      bit got, wr, ok, sw;
      logic [AW-1:0] addr, e;
      logic [8:0] len;
      int s0;
      wr_req = 1'b1;
      get_cmd(600, got, wr, addr, len);
      wr_req = 1'b0;
      e = exp_wr();
      checks++;
      if (!got || wr !== 1'b1 || addr !== e) begin
         errors++; $display("FAIL midsync_write: got=%b wr=%b addr=%h required wr=1 addr=%h", got, wr, addr, e);
      end
      $display("midsync: write burst addr=%h", addr);
      s0 = swap_cnt;
      pulse_sync();
      wait_idle(600, ok);
      repeat (5) @(negedge clk);
      #1;
      sw = model_sync();
      checks++;
      if (!ok || swap_cnt - s0 != int'(sw) || rd_buf !== 1'(m_rd_buf)) begin
         errors++; $display("FAIL midsync_noswap: idle=%b pulses=%0d rd_buf=%b required 1 %0d %0d", ok, swap_cnt - s0, rd_buf, sw, m_rd_buf);
      end
      rd_req = 1'b1;
      get_cmd(600, got, wr, addr, len);
      rd_req = 1'b0;
      e = exp_rd();
      checks++;
      if (!got || wr !== 1'b0 || addr !== e) begin
         errors++; $display("FAIL midsync_read: got=%b wr=%b addr=%h required wr=0 addr=%h", got, wr, addr, e);
      end
      $display("midsync: read burst addr=%h", addr);
      wait_idle(600, ok);
      wr_req = 1'b1;
      get_cmd(600, got, wr, addr, len);
      wr_req = 1'b0;
      e = exp_wr();
      checks++;
      if (!got || wr !== 1'b1 || addr !== e) begin
         errors++; $display("FAIL midsync_continue: got=%b wr=%b addr=%h required wr=1 addr=%h", got, wr, addr, e);
      end
      $display("midsync: write burst addr=%h", addr);
      wait_idle(600, ok);
   endtask

   task automatic test_read_wrap();
      bit got, wr, ok;
      logic [AW-1:0] addr, e;
      logic [8:0] len;
      do_reset();
      ready_lat = 1; done_dly = 256;
      rd_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         get_cmd(600, got, wr, addr, len);
         e = exp_rd();
         checks++;
         if (!got || wr !== 1'b0 || addr !== e) begin
            errors++; $display("FAIL wrap_read%0d: got=%b wr=%b addr=%h required wr=0 addr=%h", k, got, wr, addr, e);
         end
         $display("wrap: read burst addr=%h", addr);
      end
      rd_req = 1'b0;
      wait_idle(600, ok);
   endtask

   task automatic test_reset_mid_burst();
      bit got, wr, ok, seen;
      logic [AW-1:0] addr, e;
      logic [8:0] len;
      done_dly = 20;
      wr_req = 1'b1;
      get_cmd(100, got, wr, addr, len);
      wr_req = 1'b0;
      e = exp_wr();
      wait_idle(100, ok);
      ready_lat = 6;
      rd_req = 1'b1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk); #1;
         if (mem_if.mem_cmd_valid_o && rd_gnt) seen = 1;
      end
      rst = 1'b1; rd_req = 1'b0;
      #1;
      checks++;
      if (!seen || mem_if.mem_cmd_valid_o !== 1'b0 || rd_gnt !== 1'b0) begin
         errors++; $display("FAIL rst_async: saw_cmd=%b valid=%b rd_gnt=%b required 1/0/0", seen, mem_if.mem_cmd_valid_o, rd_gnt);
      end
      repeat (2) @(negedge clk);
      q_wr.delete(); q_addr.delete(); q_len.delete();
      rst = 1'b0;
      model_reset();
      ready_lat = 1;
      @(negedge clk); #1;
      checks++;
      if (rd_buf !== 1'b1 || wr_buf !== 1'b0 || wr_full !== 1'b0) begin
         errors++; $display("FAIL rst_release: rd_buf=%b wr_buf=%b wr_full=%b required 1/0/0", rd_buf, wr_buf, wr_full);
      end
      rd_req = 1'b1;
      get_cmd(100, got, wr, addr, len);
      rd_req = 1'b0;
      e = exp_rd();
      checks++;
      if (!got || wr !== 1'b0 || addr !== e) begin
         errors++; $display("FAIL rst_read_ofs: got=%b wr=%b addr=%h required wr=0 addr=%h", got, wr, addr, e);
      end
      $display("rstmid: read burst addr=%h", addr);
      wait_idle(100, ok);
      wr_req = 1'b1;
      get_cmd(100, got, wr, addr, len);
      wr_req = 1'b0;
      e = exp_wr();
      checks++;
      if (!got || wr !== 1'b1 || addr !== e) begin
         errors++; $display("FAIL rst_write_ofs: got=%b wr=%b addr=%h required wr=1 addr=%h", got, wr, addr, e);
      end
      $display("rstmid: write burst addr=%h", addr);
      wait_idle(100, ok);
   endtask

   task automatic test_random();
      bit got, wr, ok, sw, want_rd, want_wr, exp_is_wr;
      logic [AW-1:0] addr, e;
      logic [8:0] len;
      int op, n_exp, s0, g;
      do_reset();
      for (int n = 0; n < 120; n++) begin
         ready_lat = int'($urandom_range(0, 2));
         done_dly  = int'($urandom_range(3, 12));
         op = int'($urandom_range(0, 4));
         @(negedge clk);
         if (op <= 2) begin
            want_rd = (op == 0) || (op == 2);
            want_wr = (op == 1) || (op == 2);
            n_exp = int'(want_rd) + int'(want_wr && !m_full);
            rd_req = want_rd; wr_req = want_wr;
            for (int k = 0; k < n_exp; k++) begin
               get_cmd(100, got, wr, addr, len);
               exp_is_wr = !(want_rd && k == 0);
               e = exp_is_wr ? exp_wr() : exp_rd();
               if (exp_is_wr) wr_req = 1'b0; else rd_req = 1'b0;
               checks++;
               if (!got || wr !== exp_is_wr || addr !== e || len !== 9'd256) begin
                  errors++; $display("FAIL rand_cmd op%0d: got=%b wr=%b addr=%h len=%0d required wr=%b addr=%h len=256", n, got, wr, addr, len, exp_is_wr, e);
               end
               $display("rand %0d: %s burst addr=%h", n, wr ? "write" : "read", addr);
            end
            if (wr_req) begin
               g = 0;
               repeat (15) begin @(negedge clk); #1; if (wr_gnt) g++; end
               checks++;
               if (g != 0) begin
                  errors++; $display("FAIL rand_full_ignore op%0d: grant cycles=%0d required 0", n, g);
               end
               wr_req = 1'b0;
            end
            wait_idle(100, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand_idle op%0d: idle=0 required 1", n); end
         end else if (op == 3) begin
            s0 = swap_cnt;
            pulse_sync();
            repeat (3) @(negedge clk);
            #1;
            sw = model_sync();
            checks++;
            if (swap_cnt - s0 != int'(sw) || rd_buf !== 1'(m_rd_buf) ||
                wr_buf !== 1'(m_wr_buf) || wr_full !== m_full) begin
               errors++; $display("FAIL rand_sync op%0d: pulses=%0d rd_buf=%b wr_buf=%b wr_full=%b required %0d %0d %0d %b",
                                  n, swap_cnt - s0, rd_buf, wr_buf, wr_full, sw, m_rd_buf, m_wr_buf, m_full);
            end
            $display("rand %0d: sync swap=%0d", n, swap_cnt - s0);
         end else begin
            repeat (int'($urandom_range(1, 5))) @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_frame();
      test_swap();
      test_priority();
      test_sync_mid_burst();
      test_read_wrap();
      test_reset_mid_burst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
